// File: rtl/hack_mem_pkg.sv
// Shared memory-map constants, region decode enum and framebuffer write record
// for the Hack data-memory responder.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE = 15'h0000;
  localparam logic [14:0] RAM_LAST = 15'h3FFF;
  localparam logic [14:0] SCR_BASE = 15'h4000;
  localparam logic [14:0] SCR_LAST = 15'h5FFF;
  localparam logic [14:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCR,
    REG_KBD,
    REG_NONE
  } region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } fb_wr_t;

endpackage

// File: rtl/hack_sync_fifo.sv
// Synchronous FIFO with wrapping pointers and occupancy count; a push while full
// is taken only when a pop happens in the same cycle, and pops on empty are ignored.
module hack_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, SCREEN shadow with framebuffer write queue,
// and a keyboard keycode FIFO, all read combinationally through inM.
module hack_data_memory import hack_mem_pkg::*; #(
  parameter int KBD_DEPTH = 4,
  parameter int SCR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic        scr_overflow
);

  function automatic region_e decode(input logic [14:0] addr);
    if (addr <= RAM_LAST)                         return REG_RAM;
    else if (addr >= SCR_BASE && addr <= SCR_LAST) return REG_SCR;
    else if (addr == KBD_ADDR)                    return REG_KBD;
    else                                          return REG_NONE;
  endfunction

  logic [15:0] ram    [0:16383];
  logic [15:0] shadow [0:8191];

  region_e     region;
  logic        scr_wr;
  logic        kbd_pop;
  logic        fb_pop;
  logic        ready_en;
  logic [15:0] kbd_head;
  logic        kbd_full;
  logic        kbd_empty;
  logic [28:0] scr_head_bits;
  fb_wr_t      scr_head;
  logic        scr_full;
  logic        scr_empty;
  logic [$clog2(KBD_DEPTH):0] kbd_cnt;
  logic [$clog2(SCR_DEPTH):0] scr_cnt;
  logic        unused_cnt;

  assign region    = decode(addressM);
  assign scr_wr    = writeM & (region == REG_SCR);
  assign kbd_pop   = writeM & (region == REG_KBD);
  assign fb_valid  = ~scr_empty;
  assign fb_pop    = fb_valid & fb_ready;
  assign kbd_ready = ready_en & ~kbd_full;
  assign scr_head  = fb_wr_t'(scr_head_bits);
  assign fb_addr   = scr_empty ? 13'h0 : scr_head.addr;
  assign fb_data   = scr_empty ? 16'h0 : scr_head.data;
  assign unused_cnt = ^{kbd_cnt, scr_cnt};

  // Holds kbd_ready low through reset and for the release cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              scr_overflow <= 1'b0;
    else if (scr_wr && scr_full && !fb_pop)    scr_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (writeM && region == REG_RAM) ram[addressM[13:0]]    <= outM;
    if (scr_wr)                      shadow[addressM[12:0]] <= outM;
  end

  always_comb begin
    inM = 16'h0;
    case (region)
      REG_RAM: inM = ram[addressM[13:0]];
      REG_SCR: inM = shadow[addressM[12:0]];
      REG_KBD: inM = kbd_empty ? 16'h0 : kbd_head;
      default: inM = 16'h0;
    endcase
  end

  hack_sync_fifo #(.WIDTH(16), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (kbd_valid & kbd_ready),
    .push_data (kbd_code),
    .pop       (kbd_pop),
    .head      (kbd_head),
    .full      (kbd_full),
    .empty     (kbd_empty),
    .count     (kbd_cnt)
  );

  hack_sync_fifo #(.WIDTH(29), .DEPTH(SCR_DEPTH)) u_scr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (scr_wr),
    .push_data ({addressM[12:0], outM}),
    .pop       (fb_pop),
    .head      (scr_head_bits),
    .full      (scr_full),
    .empty     (scr_empty),
    .count     (scr_cnt)
  );

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory with queue scoreboards for the framebuffer
// stream and the keyboard FIFO.
module tb_hack_data_memory;
  import hack_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic [15:0] kbd_code = '0;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_valid;
  logic        fb_ready = 1'b0;
  logic        scr_overflow;

  int checks = 0;
  int errors = 0;
  fb_wr_t      fq[$];
  logic [15:0] kq[$];

  always #5 clk = ~clk;

  hack_data_memory #(.KBD_DEPTH(4), .SCR_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_valid(fb_valid), .fb_ready(fb_ready),
    .scr_overflow(scr_overflow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input logic [14:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1'b1;
    cyc();
    writeM = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    addressM = a;
    #1;
    chk(tag, 32'(inM), 32'(exp));
  endtask

  task automatic kbd_rd(input string tag);
    logic [15:0] e;
    e = (kq.size() != 0) ? kq[0] : 16'h0;
    rd(tag, KBD_ADDR, e);
  endtask

  task automatic kbd_pop();
    if (kq.size() != 0) void'(kq.pop_front());
    mem_wr(KBD_ADDR, 16'hDEAD);
  endtask

  task automatic kpush(input logic [15:0] code, input logic exp_rdy);
    kbd_code = code; kbd_valid = 1'b1;
    #1;
    chk("kbd_ready_pre_push", 32'(kbd_ready), 32'(exp_rdy));
    if (exp_rdy) kq.push_back(code);
    cyc();
    kbd_valid = 1'b0;
  endtask

  // Compares the queue head against the scoreboard; retires it if fb_ready will pop it.
  task automatic fb_head(input string tag);
    fb_wr_t e;
    if (fq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=fb_valid=%0d expected=no scoreboard entry", tag, fb_valid);
    end else begin
      e = fq[0];
      chk({tag, "_valid"}, 32'(fb_valid), 32'd1);
      chk({tag, "_addr"},  32'(fb_addr),  32'(e.addr));
      chk({tag, "_data"},  32'(fb_data),  32'(e.data));
      if (fb_ready) void'(fq.pop_front());
    end
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_fb_valid", 32'(fb_valid), 32'd0);
    chk("rst_kbd_ready", 32'(kbd_ready), 32'd0);
    chk("rst_overflow", 32'(scr_overflow), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("release_kbd_ready_low", 32'(kbd_ready), 32'd0);
    cyc();
    chk("release_kbd_ready_high", 32'(kbd_ready), 32'd1);

    // RAM write/read, read-during-write, unmapped writes
    mem_wr(15'h0010, 16'h1234);
    rd("ram_rd", 15'h0010, 16'h1234);
    addressM = 15'h0010; outM = 16'h5555; writeM = 1'b1;
    #1;
    chk("ram_rd_during_wr", 32'(inM), 32'h1234);
    cyc();
    writeM = 1'b0;
    rd("ram_rd_after_wr", 15'h0010, 16'h5555);
    mem_wr(15'h2100, 16'hA5A5);
    mem_wr(15'h6100, 16'hFFFF);
    rd("unmapped_rd", 15'h6100, 16'h0000);
    rd("unmapped_alias", 15'h2100, 16'hA5A5);
    rd("unmapped_ram_keep", 15'h0010, 16'h5555);

    // SCREEN single write
    fb_ready = 1'b1;
    fq.push_back('{addr: 13'h0005, data: 16'hBEEF});
    mem_wr(15'h4005, 16'hBEEF);
    fb_head("scr_single");
    rd("scr_shadow", 15'h4005, 16'hBEEF);
    cyc();
    chk("scr_single_drained", 32'(fb_valid), 32'd0);

    // Backpressure: 4 queued, 5th dropped
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) fq.push_back('{addr: 13'(i), data: 16'h1000 + 16'(i)});
      mem_wr(15'h4000 + 15'(i), 16'h1000 + 16'(i));
      if (i == 3) chk("ovf_not_yet", 32'(scr_overflow), 32'd0);
    end
    chk("ovf_set", 32'(scr_overflow), 32'd1);
    fb_head("bp_hold");
    rd("bp_shadow_dropped", 15'h4004, 16'h1004);
    cyc();
    fb_head("bp_hold_stable");
    fb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fb_head("bp_drain");
      cyc();
    end
    chk("bp_empty", 32'(fb_valid), 32'd0);
    chk("bp_sb_empty", 32'(fq.size()), 32'd0);

    // Full queue with simultaneous pop accepts the write
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fq.push_back('{addr: 13'h10 + 13'(i), data: 16'h2000 + 16'(i)});
      mem_wr(15'h4010 + 15'(i), 16'h2000 + 16'(i));
    end
    fb_ready = 1'b1;
    addressM = 15'h4014; outM = 16'h2004; writeM = 1'b1;
    #1;
    fb_head("fullpop_head");
    fq.push_back('{addr: 13'h14, data: 16'h2004});
    cyc();
    writeM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fb_head("fullpop_drain");
      cyc();
    end
    chk("fullpop_empty", 32'(fb_valid), 32'd0);

    // KBD basic push/read/pop
    kpush(16'h0041, 1'b1);
    kpush(16'h0042, 1'b1);
    kbd_rd("kbd_first");
    kbd_pop();
    kbd_rd("kbd_second");
    kbd_pop();
    kbd_rd("kbd_empty");
    kbd_pop();
    kbd_rd("kbd_empty_pop_ignored");
    kpush(16'h0061, 1'b1);
    kbd_rd("kbd_push_to_empty");
    kbd_pop();

    // KBD full: held push, pop with simultaneous push refused
    kpush(16'h0051, 1'b1);
    kpush(16'h0052, 1'b1);
    kpush(16'h0053, 1'b1);
    kpush(16'h0054, 1'b1);
    chk("kbd_full_ready", 32'(kbd_ready), 32'd0);
    kbd_code = 16'h0055; kbd_valid = 1'b1;
    cyc();
    chk("kbd_held_ready", 32'(kbd_ready), 32'd0);
    kbd_rd("kbd_held_head");
    void'(kq.pop_front());
    writeM = 1'b1;
    cyc();
    writeM = 1'b0;
    chk("kbd_after_pop_ready", 32'(kbd_ready), 32'd1);
    kbd_rd("kbd_after_pop_head");
    kq.push_back(16'h0055);
    cyc();
    kbd_valid = 1'b0;
    chk("kbd_refull_ready", 32'(kbd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      kbd_rd("kbd_drain");
      kbd_pop();
    end
    kbd_rd("kbd_drained");

    // Reset mid-operation
    fb_ready = 1'b0;
    fq.push_back('{addr: 13'h0020, data: 16'h3333});
    mem_wr(15'h4020, 16'h3333);
    kpush(16'h0077, 1'b1);
    fb_head("pre_reset_fb");
    kbd_rd("pre_reset_kbd");
    reset_n = 1'b0;
    fq.delete();
    kq.delete();
    #1;
    chk("mid_rst_fb_valid", 32'(fb_valid), 32'd0);
    chk("mid_rst_overflow", 32'(scr_overflow), 32'd0);
    chk("mid_rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("mid_rst_kbd_ready", 32'(kbd_ready), 32'd0);
    kbd_rd("mid_rst_kbd_rd");
    cyc();
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready_low", 32'(kbd_ready), 32'd0);
    cyc();
    chk("post_rst_ready_high", 32'(kbd_ready), 32'd1);
    chk("post_rst_fb_valid", 32'(fb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
